// File: rtl/onehot_walker.sv
// onehot_walker
// -----------------------------------------------------------------------------
// Registered one-hot position walker. Holds a W-bit index and drives its
// registered 2**W-bit one-hot decode. The index can be loaded, stepped by
// hand, or stepped automatically every PRESC cycles. End-of-range handling is
// chosen at run time: saturate, wrap or bounce (ping-pong).
//
// Parameters:
//   W      index width, output width N = 2**W (W >= 1)
//   PRESC  auto-step period in clk cycles (PRESC >= 1)
//
// Ports:
//   clk       clock
//   rst       synchronous reset, active-high
//   load      load index and direction this cycle
//   load_idx  index value used by load
//   load_dir  direction used by load (0 = up, 1 = down)
//   step      manual single-step request
//   auto_en   enable prescaled auto-stepping
//   mode      00 saturate, 01 wrap, 10 bounce, 11 saturate
//   blank     force onehot to zero, internal state unaffected
//   onehot    registered decode of the index (zero when blanked)
//   idx       current index
//   dir       current direction
//   limit     one-cycle pulse per end-of-range event
// -----------------------------------------------------------------------------
module onehot_walker #(
  parameter int W     = 3,
  parameter int PRESC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [W-1:0]        load_idx,
  input  logic                load_dir,
  input  logic                step,
  input  logic                auto_en,
  input  logic [1:0]          mode,
  input  logic                blank,
  output logic [(2**W)-1:0]   onehot,
  output logic [W-1:0]        idx,
  output logic                dir,
  output logic                limit
);

  localparam int N  = 2**W;
  // A one-state prescaler still needs a one-bit register to keep the code uniform.
  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [CW-1:0] CNT_MAX    = CW'(PRESC - 1);
  localparam logic [W-1:0]  IDX_MAX    = {W{1'b1}};
  localparam logic [N-1:0]  ONEHOT_RST = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_SAT     = 2'b00,
    MODE_WRAP    = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_SAT_ALT = 2'b11
  } mode_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  idx_q, idx_d;
  logic          dir_q, dir_d;
  logic          limit_q, limit_d;
  logic [N-1:0]  onehot_q, onehot_d;

  logic tick;
  logic adv;
  logic at_end;

  // Next-state logic. Load beats any advance; a step and a tick arriving
  // together collapse into a single advance. The prescaler free-runs only
  // while auto_en is high and restarts from zero whenever a load happens.
  always_comb begin
    tick     = auto_en && (cnt_q == CNT_MAX);
    adv      = step | tick;
    at_end   = dir_q ? (idx_q == '0) : (idx_q == IDX_MAX);

    cnt_d    = '0;
    idx_d    = idx_q;
    dir_d    = dir_q;
    limit_d  = 1'b0;
    onehot_d = '0;

    if (!load && auto_en && !tick) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (load) begin
      idx_d = load_idx;
      dir_d = load_dir;
    end else if (adv) begin
      if (!at_end) begin
        idx_d = dir_q ? (idx_q - W'(1)) : (idx_q + W'(1));
      end else begin
        limit_d = 1'b1;
        case (mode_e'(mode))
          MODE_WRAP: begin
            idx_d = dir_q ? IDX_MAX : '0;
          end
          // Turn around and move one step back inward, so each endpoint is
          // shown for exactly one advance period. For W=1 this alternates 0,1.
          MODE_BOUNCE: begin
            dir_d = ~dir_q;
            idx_d = dir_q ? (idx_q + W'(1)) : (idx_q - W'(1));
          end
          default: begin
            idx_d = idx_q;
          end
        endcase
      end
    end

    // The decode is taken from the next index so it lines up with idx.
    if (!blank) begin
      onehot_d[idx_d] = 1'b1;
    end
  end

  // State and output registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      limit_q  <= 1'b0;
      onehot_q <= ONEHOT_RST;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      limit_q  <= limit_d;
      onehot_q <= onehot_d;
    end
  end

  assign onehot = onehot_q;
  assign idx    = idx_q;
  assign dir    = dir_q;
  assign limit  = limit_q;

endmodule

// File: tb/tb_onehot_walker.sv
// tb_onehot_walker
// -----------------------------------------------------------------------------
// Testbench for onehot_walker with W=3, PRESC=4. A table of directed vectors
// covers reset, load, wrap, saturate, bounce and blanking; hand-written
// sequences cover auto-stepping and load/step/tick priority; a randomized run
// is compared cycle by cycle against an integer reference model.
// -----------------------------------------------------------------------------
module tb_onehot_walker;

  localparam int W     = 3;
  localparam int N     = 2**W;
  localparam int PRESC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] loadIdx = '0;
  logic         loadDir = 1'b0;
  logic         step = 1'b0;
  logic         autoEn = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         blank = 1'b0;
  logic [N-1:0] onehot;
  logic [W-1:0] idx;
  logic         dir;
  logic         limit;

  int testCount = 0;
  int failCount = 0;

  // Reference model state, kept as plain integers.
  int           mIdx = 0;
  bit           mDir = 1'b0;
  int           mCnt = 0;
  bit           mLimit = 1'b0;
  logic [N-1:0] mOnehot = '0;

  typedef struct {
    logic         r;
    logic         ld;
    logic [W-1:0] lidx;
    logic         ldir;
    logic         stp;
    logic         aen;
    logic [1:0]   md;
    logic         blk;
    logic [N-1:0] expOnehot;
    logic [W-1:0] expIdx;
    logic         expDir;
    logic         expLimit;
  } vector_t;

  vector_t vecs[$];

  onehot_walker #(.W(W), .PRESC(PRESC)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_idx (loadIdx),
    .load_dir (loadDir),
    .step     (step),
    .auto_en  (autoEn),
    .mode     (mode),
    .blank    (blank),
    .onehot   (onehot),
    .idx      (idx),
    .dir      (dir),
    .limit    (limit)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one clock edge using the current inputs.
  // An advance that would leave 0..N-1 is an end-of-range event.
  task automatic modelEdge();
    int  delta;
    int  nxt;
    bit  tick;
    if (rst) begin
      mIdx    = 0;
      mDir    = 1'b0;
      mCnt    = 0;
      mLimit  = 1'b0;
      mOnehot = N'(1);
      return;
    end
    tick   = autoEn && (mCnt == PRESC - 1);
    mLimit = 1'b0;
    if (load) begin
      mIdx = int'(loadIdx);
      mDir = loadDir;
      mCnt = 0;
    end else begin
      mCnt = autoEn ? (mCnt + 1) % PRESC : 0;
      if (step || tick) begin
        delta = mDir ? -1 : 1;
        nxt   = mIdx + delta;
        if (nxt >= 0 && nxt < N) begin
          mIdx = nxt;
        end else begin
          mLimit = 1'b1;
          case (mode)
            2'b01: mIdx = (nxt + N) % N;
            2'b10: begin
              mDir = !mDir;
              mIdx = mIdx - delta;
            end
            default: mIdx = mIdx;
          endcase
        end
      end
    end
    mOnehot = blank ? '0 : (N'(1) << mIdx);
  endtask

  // Drive one cycle of inputs, update the model, and wait until just after
  // the edge that consumes them.
  task automatic applyStimulus(input logic r, input logic ld, input logic [W-1:0] lidx,
                               input logic ldir, input logic stp, input logic aen,
                               input logic [1:0] md, input logic blk);
    rst     = r;
    load    = ld;
    loadIdx = lidx;
    loadDir = ldir;
    step    = stp;
    autoEn  = aen;
    mode    = md;
    blank   = blk;
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eo,
                             input logic [W-1:0] ei, input logic ed, input logic el);
    testCount++;
    if (onehot !== eo || idx !== ei || dir !== ed || limit !== el) begin
      failCount++;
      $display("[TB] FAIL %s: got onehot=%h idx=%0d dir=%b limit=%b, want onehot=%h idx=%0d dir=%b limit=%b",
               name, onehot, idx, dir, limit, eo, ei, ed, el);
    end
  endtask

  task automatic addVec(input logic r, input logic ld, input logic [W-1:0] lidx,
                        input logic ldir, input logic stp, input logic aen,
                        input logic [1:0] md, input logic blk,
                        input logic [N-1:0] eo, input logic [W-1:0] ei,
                        input logic ed, input logic el);
    vector_t v;
    v.r = r; v.ld = ld; v.lidx = lidx; v.ldir = ldir; v.stp = stp; v.aen = aen;
    v.md = md; v.blk = blk; v.expOnehot = eo; v.expIdx = ei; v.expDir = ed; v.expLimit = el;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] expI;
    logic         r;
    logic         ld;
    logic         stp;
    logic         aen;
    logic         blk;

    // rst ld lidx ldir stp aen mode blk | onehot idx dir limit
    addVec(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    addVec(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0);
    addVec(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'h40, 3'd6, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'h01, 3'd0, 1'b0, 1'b1);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0);
    addVec(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1);
    addVec(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 3'd1, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'h02, 3'd1, 1'b0, 1'b1);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].ld, vecs[i].lidx, vecs[i].ldir,
                    vecs[i].stp, vecs[i].aen, vecs[i].md, vecs[i].blk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOnehot, vecs[i].expIdx,
                  vecs[i].expDir, vecs[i].expLimit);
    end

    // Bounce driven by the prescaler: from 6 going up, idx changes every 4
    // cycles to 7, 6, 5, turning around (with one limit pulse) on 7 -> 6.
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    checkOutput("bounceLoad", 8'h40, 3'd6, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      expI = (k < 4) ? 3'd6 : (k < 8) ? 3'd7 : (k < 12) ? 3'd6 : 3'd5;
      checkOutput($sformatf("bounceAuto%0d", k), N'(1) << expI, expI,
                  (k >= 8) ? 1'b1 : 1'b0, (k == 8) ? 1'b1 : 1'b0);
    end

    // Load arriving together with a step and a tick wins, and restarts the
    // prescaler; later a step coinciding with a tick moves only once.
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    checkOutput("prioLoad0", 8'h01, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    end
    checkOutput("prioPreTick", 8'h01, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    checkOutput("prioLoad", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    end
    checkOutput("prescCleared", 8'h04, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    checkOutput("firstTick", 8'h02, 3'd1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    checkOutput("stepPlusTick", 8'h01, 3'd0, 1'b1, 1'b0);

    // Randomized run compared against the reference model every cycle.
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("randReset", mOnehot, W'(mIdx), mDir, mLimit);
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      stp = ($urandom_range(0, 2) == 0);
      aen = ($urandom_range(0, 3) != 0);
      blk = ($urandom_range(0, 9) == 0);
      applyStimulus(r, ld, W'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                    stp, aen, 2'($urandom_range(0, 3)), blk);
      checkOutput($sformatf("rand%0d", k), mOnehot, W'(mIdx), mDir, mLimit);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/onehot_walker.md
Name: onehot_walker

Overview:
Parametrised, registered successor to the 3-to-8 one-hot decoder. Holds a W-bit position index and drives its registered 2**W-bit one-hot decode. The index can be loaded directly, stepped manually, or stepped automatically by an internal prescaler. End-of-range handling is selectable: saturate, wrap, or bounce (ping-pong). Used as an LED/segment scanner, chaser or channel-select sequencer.

Parameters:
W, 3, index width; output width N = 2**W (W >= 1)
PRESC, 4, auto-step period in clk cycles (PRESC >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
load  in  1  load index and direction this cycle
load_idx  in  W  index value for load
load_dir  in  1  direction for load: 0 = up (increment), 1 = down
step  in  1  manual single-step request
auto_en  in  1  enable prescaled auto-stepping
mode  in  2  00 saturate, 01 wrap, 10 bounce, 11 treated as 00
blank  in  1  force onehot to all zeros; internal state unaffected
onehot  out  N  registered decode, onehot == 1 << idx unless blanked
idx  out  W  current index
dir  out  1  current direction
limit  out  1  one-cycle pulse on an end-of-range event

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: idx=0, dir=0, onehot=1 (bit 0; all zeros if blank is high on the following cycle), limit=0, prescaler=0. Reset overrides every other input.
- All outputs are registered. A request sampled at edge t is reflected on the outputs after edge t (1-cycle latency).
- blank is registered with the decode: onehot = blank ? 0 : (1 << idx_next).
- Prescaler:
  - When auto_en=0, the counter is held at 0.
  - When auto_en=1, the counter runs 0..PRESC-1 and wraps. An internal tick is generated in the cycle where counter == PRESC-1.
  - With PRESC=1, tick fires every cycle.
  - A load clears the counter to 0.
- Effective step: adv = step | tick. Simultaneous step and tick give one advance, not two.
- Priority: rst > load > adv > hold.
- Load: idx <= load_idx, dir <= load_dir, limit <= 0. Any step or tick in the same cycle is ignored.
- Advance, not at end: idx <= idx+1 (dir=0) or idx-1 (dir=1); limit <= 0.
- "At end" means idx == N-1 with dir=0, or idx == 0 with dir=1. On advance at end:
  - Saturate (00/11): idx and dir held; limit <= 1.
  - Wrap (01): idx <= 0 (dir=0) or N-1 (dir=1); dir held; limit <= 1.
  - Bounce (10): dir toggles; idx moves one step the other way (N-1 -> N-2, or 0 -> 1); limit <= 1. Each endpoint value is output for exactly one advance period.
  - Bounce with W=1: sequence is 0,1,0,1..., with limit on every advance.
- limit stays high for exactly one cycle per event. Back-to-back events (e.g. saturate with step held) give limit high continuously, one per cycle.
- A mode change takes effect on the next advance; idx and dir are not altered.
- Index arithmetic is modulo N in W bits. load_idx covers the full range, so no range check is needed.
- Reset mid-sequence returns all state to reset values on the next edge, regardless of load, step or auto_en.

Test Plan:
- Reset, W=3: rst=1 for 2 cycles -> onehot=8'h01, idx=0, dir=0, limit=0. Then load_idx=5, load=1 -> onehot=8'h20 one cycle later.
- Wrap, up: mode=01, idx=6, dir=0, step held 3 cycles -> idx 7, 0, 1; onehot 8'h80, 8'h01, 8'h02; limit high only in the cycle idx becomes 0.
- Saturate, down: mode=00, idx=1, dir=1, step held 3 cycles -> idx 0, 0, 0; limit=0, then 1, then 1; dir stays 1.
- Bounce with auto: mode=10, PRESC=4, auto_en=1 from idx=6, dir=0 -> idx changes every 4 cycles: 7, 6, 5; dir goes to 1 when idx goes 7->6; a single limit pulse on that transition.
- Priority: load=1, load_idx=2, load_dir=1, step=1 and tick in the same cycle -> idx=2, dir=1, limit=0, prescaler=0. Simultaneous step and tick without load -> single increment.
- Blank and reset: blank=1 during stepping -> onehot=0 while idx still advances; releasing blank shows 1 << idx. rst asserted mid-bounce -> idx=0, dir=0, onehot=8'h01 next cycle.
